// File: rtl/shift_pkg.sv
// shift_pkg: op encodings, FSM states and the shared shift function for shift_unit_iter.
package shift_pkg;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Shifts the low xlen bits of d by n (n < xlen); upper result bits are zero.
    function automatic logic [63:0] shift_fn(input logic [63:0] d, input logic [6:0] n,
                                             input logic [1:0] op, input int xlen);
        logic [63:0] m, dm, sx;
        logic signed [63:0] sra;
        m   = (xlen >= 64) ? '1 : (64'd1 << xlen) - 64'd1;
        dm  = d & m;
        sx  = |(dm & (64'd1 << (xlen - 1))) ? dm | ~m : dm;
        sra = $signed(sx) >>> n;
        return m & (op == SH_SLL ? dm << n :
                    op == SH_SRL ? dm >> n :
                    op == SH_SRA ? sra :
                    (dm >> n) | (dm << (7'(xlen) - n)));
    endfunction

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational shift of data by min(k, STEP) for the given op.
module shift_step
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic [XLEN-1:0]         data,
    input  logic [$clog2(XLEN):0]   k,
    input  logic [1:0]              op,
    output logic [XLEN-1:0]         res,
    output logic [$clog2(XLEN):0]   used
);
    localparam int KW = $clog2(XLEN) + 1;

    assign used = (k > KW'(STEP)) ? KW'(STEP) : k;
    assign res  = XLEN'(shift_fn(64'(data), 7'(used), op, XLEN));

endmodule

// File: rtl/shift_unit_iter.sv
// shift_unit_iter: multi-cycle SLL/SRL/SRA/ROR shifter with valid/ready handshakes and flush.
// Define SHIFT_FAST_PATH_EN to compute the full shift at accept (always 1-cycle latency).
module shift_unit_iter
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in1,
    input  logic [XLEN-1:0]  in2,
    input  logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out,
    input  logic             flush
);
    localparam int SHW = $clog2(XLEN);

    state_t          state;
    logic [XLEN-1:0] data;
    logic [1:0]      op;
    logic [SHW-1:0]  rem;
    logic [XLEN-1:0] sd, res;
    logic [SHW:0]    sk, used;
    logic [1:0]      so;
    logic            unused_in2;

    assign unused_in2 = ^in2[XLEN-1:SHW];
    assign out        = data;

`ifdef SHIFT_FAST_PATH_EN
    localparam int SST = XLEN;
    // In IDLE the shifter sees the incoming request so the result is ready at accept.
    assign sd = (state == IDLE) ? in1 : data;
    assign sk = (state == IDLE) ? {1'b0, in2[SHW-1:0]} : {1'b0, rem};
    assign so = (state == IDLE) ? sel : op;
`else
    localparam int SST = STEP;
    assign sd = data;
    assign sk = {1'b0, rem};
    assign so = op;
`endif

    shift_step #(.XLEN(XLEN), .STEP(SST)) u_step (
        .data (sd),
        .k    (sk),
        .op   (so),
        .res  (res),
        .used (used)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            data      <= '0;
            op        <= SH_SLL;
            rem       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            rem       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                op        <= sel;
                in_ready  <= 1'b0;
`ifdef SHIFT_FAST_PATH_EN
                data      <= res;
                state     <= DONE;
                out_valid <= 1'b1;
`else
                data      <= in1;
                rem       <= in2[SHW-1:0];
                state     <= (in2[SHW-1:0] != '0) ? BUSY : DONE;
                out_valid <= (in2[SHW-1:0] == '0);
`endif
            end
        end else if (state == BUSY) begin
            data <= res;
            rem  <= rem - used[SHW-1:0];
            if (rem == used[SHW-1:0]) begin
                state     <= DONE;
                out_valid <= 1'b1;
            end
        end else if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_unit_iter.sv
// tb_shift_unit_iter: directed + random scoreboard bench for shift_unit_iter (XLEN=32, STEP=4).
module tb_shift_unit_iter;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, flush;
    logic [31:0] in1, in2, out;
    logic [1:0]  sel;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    shift_unit_iter #(.XLEN(32), .STEP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flush     (flush)
    );

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
        logic [31:0] r;
        int n, j;
        n = int'(b[4:0]);
        for (int i = 0; i < 32; i++) begin
            j = i + n;
            case (s)
                2'b00:   r[i] = (i >= n) ? a[i-n] : 1'b0;
                2'b01:   r[i] = (j < 32) ? a[j] : 1'b0;
                2'b10:   r[i] = (j < 32) ? a[j] : a[31];
                default: r[i] = a[j%32];
            endcase
        end
        return r;
    endfunction

    function automatic int exp_lat(input int n);
`ifdef SHIFT_FAST_PATH_EN
        return 1 + 0 * n;
`else
        return 1 + (n + 3) / 4;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                          input string tag, input bit hold);
        exp_t e;
        int   lat;
        logic [31:0] held;
        @(negedge clk);
        in1 = a; in2 = b; sel = s; in_valid = 1'b1; out_ready = !hold;
        e.res = model(a, b, s);
        e.lat = exp_lat(int'(b[4:0]));
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in1 = $urandom; in2 = $urandom;
        lat = 1;
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        e = q.pop_front();
        check({tag, "_out"}, out, e.res);
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        if (hold) begin
            held = out;
            repeat (5) begin
                @(negedge clk);
                check({tag, "_hold_out"}, out, held);
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        in1 = '0; in2 = '0; sel = 2'b00;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        run_op(32'h0000_00F1, 32'd5,  2'b00, "sll5", 1'b0);
        check("sll5_const", model(32'h0000_00F1, 32'd5, 2'b00), 32'h0000_1E20);
        run_op(32'h8000_0000, 32'd31, 2'b10, "sra31", 1'b0);
        check("sra31_const", model(32'h8000_0000, 32'd31, 2'b10), 32'hFFFF_FFFF);
        run_op(32'h0000_0001, 32'd1,  2'b11, "ror1", 1'b0);
        run_op(32'hF000_0000, 32'd32, 2'b01, "srl32", 1'b0);
        run_op(32'h1234_5678, 32'd8,  2'b01, "bp_srl8", 1'b1);

        // Flush two cycles after accepting a long shift.
        @(negedge clk);
        in1 = 32'h0000_00F1; in2 = 32'd20; sel = 2'b00; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
`ifndef SHIFT_FAST_PATH_EN
        check("flush_pre_valid0", 32'(out_valid), 32'd0);
`endif
        @(negedge clk);
`ifndef SHIFT_FAST_PATH_EN
        check("flush_pre_valid1", 32'(out_valid), 32'd0);
`endif
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("flush_stays_idle", 32'(out_valid), 32'd0);
        end

        // Flush together with in_valid must not accept.
        @(negedge clk);
        in1 = 32'hDEAD_BEEF; in2 = 32'd3; sel = 2'b01; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flushacc_in_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            check("flushacc_no_valid", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        in1 = 32'h0000_00F1; in2 = 32'd20; sel = 2'b00; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out", out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'hA5A5_0F0F, 32'd13, 2'b11, "post_rst", 1'b0);

        for (int i = 0; i < 24; i++)
            run_op($urandom, $urandom_range(0, 63), 2'($urandom_range(0, 3)), "rand", 1'b0);

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
